// File: rtl/parser_conf_arbiter_pkg.sv
// Shared types and constants for the parser rule-configuration arbiter.
package parser_conf_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2,
    RESP    = 2'd3
  } conf_state_e;

  localparam int LAYER_SEL_MSB = 31;
  localparam int LAYER_SEL_LSB = 24;

  localparam int DEF_TIMEOUT = 15;
  localparam int DEF_CNT_W   = $clog2(DEF_TIMEOUT + 1);

  function automatic int cnt_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/parser_conf_arbiter_if.sv
// Configuration bus: master request/response side plus the per-layer rule port side.
interface parser_conf_arbiter_if #(
  parameter int NUM_REQ   = 2,
  parameter int NUM_LAYER = 4
);
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_wr;
  logic [NUM_REQ-1:0][31:0]   req_addr;
  logic [NUM_REQ-1:0][31:0]   req_wdata;
  logic [NUM_REQ-1:0]         req_ready;
  logic [NUM_REQ-1:0]         resp_valid;
  logic [31:0]                resp_rdata;
  logic                       resp_err;
  logic [NUM_LAYER-1:0]       rule_wren;
  logic [NUM_LAYER-1:0]       rule_rden;
  logic [31:0]                rule_addr;
  logic [31:0]                rule_wdata;
  logic [NUM_LAYER-1:0]       rule_rdata_valid;
  logic [NUM_LAYER-1:0][31:0] rule_rdata;

  // Environment view: configuration masters and parser layers.
  modport master (
    output req_valid, req_wr, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  rule_wren, rule_rden, rule_addr, rule_wdata,
    output rule_rdata_valid, rule_rdata
  );

  // Arbiter view.
  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output rule_wren, rule_rden, rule_addr, rule_wdata,
    input  rule_rdata_valid, rule_rdata
  );
endinterface

// File: rtl/parser_conf_arbiter_rr.sv
// Combinational round-robin arbiter: one-hot grant to the first request at or after i_ptr.
module rr_arbiter
  import parser_conf_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  localparam int PTR_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_gnt
);

  logic w_found;
  logic w_hit;

  // Two passes: indices from the pointer upward, then the wrapped low indices.
  always_comb begin
    o_gnt   = '0;
    w_found = 1'b0;
    w_hit   = 1'b0;
    for (int j = 0; j < NUM_REQ; j++) begin
      w_hit    = i_req[j] && !w_found && (j >= int'(i_ptr));
      o_gnt[j] = o_gnt[j] | w_hit;
      w_found  = w_found | w_hit;
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      w_hit    = i_req[j] && !w_found && (j < int'(i_ptr));
      o_gnt[j] = o_gnt[j] | w_hit;
      w_found  = w_found | w_hit;
    end
  end

endmodule

// File: rtl/parser_conf_arbiter.sv
// Serialises configuration accesses from several masters onto the parser layers' rule ports,
// with round-robin fairness, layer decode, and a read timeout.
module parser_conf_arbiter
  import parser_conf_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int NUM_LAYER = 4,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  parser_conf_arbiter_if.slave bus
);

  localparam int               PTR_W    = idx_width(NUM_REQ);
  localparam int               CNT_W    = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  conf_state_e          r_state;
  conf_state_e          w_state_nxt;
  logic [PTR_W-1:0]     r_rr_ptr;
  logic [PTR_W-1:0]     w_rr_ptr_nxt;
  logic [PTR_W-1:0]     w_gnt_idx;
  logic [NUM_REQ-1:0]   w_arb_req;
  logic [NUM_REQ-1:0]   w_gnt;
  logic [NUM_REQ-1:0]   r_owner;
  logic                 r_wr;
  logic [31:0]          r_addr;
  logic [31:0]          r_wdata;
  logic [7:0]           r_layer;
  logic [31:0]          r_rdata;
  logic                 r_err;
  logic [CNT_W-1:0]     r_cnt;

  logic                 w_accept;
  logic                 w_acc_wr;
  logic [31:0]          w_acc_addr;
  logic [31:0]          w_acc_wdata;
  logic [7:0]           w_acc_layer;
  logic                 w_acc_bad;
  logic                 w_sel_valid;
  logic [31:0]          w_sel_rdata;
  logic                 w_timeout;

  logic [NUM_REQ-1:0]   w_req_ready;
  logic [NUM_REQ-1:0]   w_resp_valid;
  logic [31:0]          w_resp_rdata;
  logic                 w_resp_err;
  logic [NUM_LAYER-1:0] w_rule_wren;
  logic [NUM_LAYER-1:0] w_rule_rden;

  // Ready must stay low while reset is asserted even though arbitration is combinational.
  assign w_arb_req = bus.req_valid & {NUM_REQ{(r_state == IDLE) && !i_rst}};

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
    .i_req (w_arb_req),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_gnt)
  );

  // Mux the granted master's request and pick the addressed layer's read return.
  always_comb begin
    w_accept    = |w_gnt;
    w_acc_wr    = 1'b0;
    w_acc_addr  = 32'd0;
    w_acc_wdata = 32'd0;
    w_gnt_idx   = '0;
    for (int m = 0; m < NUM_REQ; m++) begin
      w_acc_wr    = w_acc_wr | (w_gnt[m] & bus.req_wr[m]);
      w_acc_addr  = w_acc_addr | ({32{w_gnt[m]}} & bus.req_addr[m]);
      w_acc_wdata = w_acc_wdata | ({32{w_gnt[m]}} & bus.req_wdata[m]);
      w_gnt_idx   = w_gnt_idx | (PTR_W'(m) & {PTR_W{w_gnt[m]}});
    end
    w_acc_layer  = w_acc_addr[LAYER_SEL_MSB:LAYER_SEL_LSB];
    w_acc_bad    = ({24'd0, w_acc_layer} >= 32'(NUM_LAYER));
    w_rr_ptr_nxt = (int'(w_gnt_idx) >= NUM_REQ - 1) ? '0 : w_gnt_idx + PTR_W'(1);

    w_sel_valid = 1'b0;
    w_sel_rdata = 32'd0;
    for (int l = 0; l < NUM_LAYER; l++) begin
      w_sel_valid = w_sel_valid | (bus.rule_rdata_valid[l] & (r_layer == 8'(l)));
      w_sel_rdata = w_sel_rdata | ({32{r_layer == 8'(l)}} & bus.rule_rdata[l]);
    end
    w_timeout = (r_cnt == CNT_LAST);
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; returned read data beats a simultaneous timeout.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = w_acc_bad ? RESP : ISSUE;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      ISSUE: begin
        if (r_wr || w_sel_valid) begin
          w_state_nxt = RESP;
        end else begin
          w_state_nxt = WAIT_RD;
        end
      end
      WAIT_RD: begin
        if (w_sel_valid || w_timeout) begin
          w_state_nxt = RESP;
        end else begin
          w_state_nxt = WAIT_RD;
        end
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Access context, round-robin pointer, timeout counter and response payload.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rr_ptr <= '0;
      r_owner  <= '0;
      r_wr     <= 1'b0;
      r_addr   <= 32'd0;
      r_wdata  <= 32'd0;
      r_layer  <= 8'd0;
      r_rdata  <= 32'd0;
      r_err    <= 1'b0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_owner  <= w_gnt;
            r_wr     <= w_acc_wr;
            r_addr   <= w_acc_addr;
            r_wdata  <= w_acc_wdata;
            r_layer  <= w_acc_layer;
            r_err    <= w_acc_bad;
            r_rdata  <= 32'd0;
            r_rr_ptr <= w_rr_ptr_nxt;
          end
        end
        ISSUE: begin
          r_cnt <= '0;
          if (!r_wr && w_sel_valid) begin
            r_rdata <= w_sel_rdata;
          end
        end
        WAIT_RD: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_sel_valid) begin
            r_rdata <= w_sel_rdata;
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_rdata <= 32'd0;
          end
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

  // Output decode from the registered state and access context.
  always_comb begin
    w_req_ready  = w_gnt;
    w_resp_valid = (r_state == RESP) ? r_owner : '0;
    w_resp_rdata = (r_state == RESP) ? r_rdata : 32'd0;
    w_resp_err   = (r_state == RESP) & r_err;
    for (int l = 0; l < NUM_LAYER; l++) begin
      w_rule_wren[l] = (r_state == ISSUE) && r_wr && (r_layer == 8'(l));
      w_rule_rden[l] = (r_state == ISSUE) && !r_wr && (r_layer == 8'(l));
    end
  end

  assign bus.req_ready  = w_req_ready;
  assign bus.resp_valid = w_resp_valid;
  assign bus.resp_rdata = w_resp_rdata;
  assign bus.resp_err   = w_resp_err;
  assign bus.rule_wren  = w_rule_wren;
  assign bus.rule_rden  = w_rule_rden;
  assign bus.rule_addr  = r_addr;
  assign bus.rule_wdata = r_wdata;

endmodule

// File: tb/tb_parser_conf_arbiter.sv
// Random + directed bench for parser_conf_arbiter with a queue-based scoreboard.
module tb_parser_conf_arbiter;

  localparam int NR = 2;
  localparam int NL = 4;
  localparam int TO = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  parser_conf_arbiter_if #(.NUM_REQ(NR), .NUM_LAYER(NL)) bus ();

  parser_conf_arbiter #(.NUM_REQ(NR), .NUM_LAYER(NL), .TIMEOUT(TO)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int cyc; logic [NR-1:0] owner; logic [31:0] rdata; logic err;} resp_t;
  typedef struct {int cyc; logic wr; int layer; logic [31:0] addr; logic [31:0] wdata;} strb_t;

  resp_t       resp_q[$];
  strb_t       strb_q[$];
  logic        outstanding = 1'b0;
  int          exp_ptr = 0;
  logic [31:0] last_addr = 32'd0;
  logic [31:0] last_wdata = 32'd0;
  logic        prev_rst = 1'b0;
  logic [NR-1:0] accepted = '0;
  logic        sched_on = 1'b0;
  int          sched_cyc = 0;
  int          sched_layer = 0;
  logic [31:0] sched_data = 32'd0;
  int          force_d = -1;
  logic [31:0] force_data = 32'd0;
  int          gen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // The granted master is the first valid one at or after the round-robin pointer.
  function automatic logic [NR-1:0] rr_expect(input logic [NR-1:0] v, input int ptr);
    logic [NR-1:0] g;
    logic f;
    int j;
    g = '0;
    f = 1'b0;
    for (int k = 0; k < NR; k++) begin
      j = (ptr + k) % NR;
      if (!f && v[j]) begin
        g[j] = 1'b1;
        f = 1'b1;
      end
    end
    return g;
  endfunction

  task automatic on_accept(input int m);
    logic [31:0] a;
    int          layer;
    int          d;
    logic [31:0] data;
    logic [NR-1:0] own;
    a = bus.req_addr[m];
    layer = int'(a[31:24]);
    own = '0;
    own[m] = 1'b1;
    if (layer >= NL) begin
      resp_q.push_back('{cyc + 1, own, 32'd0, 1'b1});
      sched_on = 1'b0;
    end else begin
      strb_q.push_back('{cyc + 1, bus.req_wr[m], layer, a, bus.req_wdata[m]});
      if (bus.req_wr[m]) begin
        resp_q.push_back('{cyc + 2, own, 32'd0, 1'b0});
        sched_on = 1'b0;
      end else begin
        if (force_d >= 0) begin
          d = force_d;
          data = force_data;
          force_d = -1;
        end else begin
          d = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 3) : $urandom_range(0, TO + 2);
          data = $urandom;
        end
        sched_on = 1'b1;
        sched_cyc = cyc + 1 + d;
        sched_layer = layer;
        sched_data = data;
        if (d <= TO) resp_q.push_back('{cyc + 2 + d, own, data, 1'b0});
        else         resp_q.push_back('{cyc + 2 + TO, own, 32'd0, 1'b1});
      end
    end
    outstanding = 1'b1;
    exp_ptr = (m + 1) % NR;
    last_addr = a;
    last_wdata = bus.req_wdata[m];
    accepted[m] = 1'b1;
  endtask

  task automatic monitor_cycle();
    logic [NL-1:0] ev;
    strb_t s;
    resp_t r;
    int acc_m;
    if (rst) begin
      chk("ready_in_reset", 32'(bus.req_ready), 32'd0);
      if (prev_rst) begin
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
        chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
        chk("rst_strobes", 32'({bus.rule_wren, bus.rule_rden}), 32'd0);
        chk("rst_rule_addr", bus.rule_addr, 32'd0);
        chk("rst_rule_wdata", bus.rule_wdata, 32'd0);
      end
      resp_q.delete();
      strb_q.delete();
      outstanding = 1'b0;
      exp_ptr = 0;
      last_addr = 32'd0;
      last_wdata = 32'd0;
      sched_on = 1'b0;
      prev_rst = 1'b1;
      return;
    end
    prev_rst = 1'b0;
    chk("rule_addr_hold", bus.rule_addr, last_addr);
    chk("rule_wdata_hold", bus.rule_wdata, last_wdata);

    if (outstanding) chk("ready_busy", 32'(bus.req_ready), 32'd0);
    else             chk("ready_rr", 32'(bus.req_ready), 32'(rr_expect(bus.req_valid, exp_ptr)));

    if (strb_q.size() > 0 && strb_q[0].cyc == cyc) begin
      s = strb_q.pop_front();
      ev = '0;
      ev[s.layer] = 1'b1;
      chk("strobe_wren", 32'(bus.rule_wren), s.wr ? 32'(ev) : 32'd0);
      chk("strobe_rden", 32'(bus.rule_rden), s.wr ? 32'd0 : 32'(ev));
      chk("strobe_addr", bus.rule_addr, s.addr);
      if (s.wr) chk("strobe_wdata", bus.rule_wdata, s.wdata);
    end else begin
      chk("strobe_spurious", 32'({bus.rule_wren, bus.rule_rden}), 32'd0);
    end

    if (resp_q.size() > 0 && resp_q[0].cyc == cyc) begin
      r = resp_q.pop_front();
      chk("resp_valid", 32'(bus.resp_valid), 32'(r.owner));
      chk("resp_rdata", bus.resp_rdata, r.rdata);
      chk("resp_err", 32'(bus.resp_err), 32'(r.err));
      outstanding = 1'b0;
    end else begin
      chk("resp_spurious", 32'(bus.resp_valid), 32'd0);
    end

    acc_m = -1;
    for (int m = NR - 1; m >= 0; m--) if (bus.req_ready[m] && bus.req_valid[m]) acc_m = m;
    if (acc_m >= 0 && !outstanding) on_accept(acc_m);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      monitor_cycle();
    end
  end

  task automatic new_req(input int m, input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    bus.req_valid[m] = 1'b1;
    bus.req_wr[m]    = wr;
    bus.req_addr[m]  = addr;
    bus.req_wdata[m] = wdata;
  endtask

  task automatic rand_req(input int m);
    logic [7:0] layer;
    logic [31:0] lo;
    layer = 8'($urandom_range(0, 5));
    lo = $urandom;
    new_req(m, 1'($urandom_range(0, 1)), {layer, lo[23:0]}, $urandom);
  endtask

  // Drive all environment inputs just after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    for (int m = 0; m < NR; m++) begin
      if (accepted[m]) begin
        bus.req_valid[m] = 1'b0;
        accepted[m] = 1'b0;
      end
      if (!bus.req_valid[m] && (gen == 2 || (gen == 1 && $urandom_range(0, 2) == 0))) rand_req(m);
    end
    for (int l = 0; l < NL; l++) begin
      if (sched_on && l == sched_layer) begin
        bus.rule_rdata_valid[l] = (cyc == sched_cyc);
        bus.rule_rdata[l] = sched_data;
      end else begin
        bus.rule_rdata_valid[l] = ($urandom_range(0, 3) == 0);
        bus.rule_rdata[l] = $urandom;
      end
    end
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_wr = '0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    bus.rule_rdata_valid = '0;
    bus.rule_rdata = '0;
    repeat (3) step();
    rst = 1'b0;
    gen = 1;
    repeat (800) step();
    gen = 2;
    repeat (300) step();
    gen = 0;
    repeat (40) step();

    new_req(0, 1'b1, 32'h0100_0010, 32'hA5A5_0001);
    repeat (6) step();
    force_d = 0;
    force_data = 32'h1234_5678;
    new_req(1, 1'b0, 32'h0200_0004, 32'd0);
    repeat (6) step();
    new_req(0, 1'b1, 32'h0700_0000, 32'h0BAD_0BAD);
    repeat (4) step();
    force_d = TO + 1;
    force_data = 32'hDEAD_BEEF;
    new_req(1, 1'b0, 32'h0300_0000, 32'd0);
    repeat (TO + 6) step();
    force_d = 2;
    force_data = 32'hCAFE_0003;
    new_req(0, 1'b0, 32'h0300_0008, 32'd0);
    repeat (8) step();

    force_d = 1000;
    new_req(1, 1'b0, 32'h0300_000C, 32'd0);
    repeat (6) step();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    new_req(0, 1'b1, 32'h0000_0020, 32'h0000_0055);
    new_req(1, 1'b1, 32'h0100_0024, 32'h0000_0066);
    repeat (30) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
